// File: rtl/fsm_pseq_sequencer.sv
// Parametrised linear control sequencer: per-state advance, reverse step, direct load,
// and per-visit dwell counting with a one-shot timeout.
module fsm_pseq_sequencer #(
    parameter int NS   = 16,
    parameter bit WRAP = 1'b1,
    parameter int DW   = 16,
    localparam int W   = $clog2(NS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NS-1:0] adv,
    input  logic          bck,
    input  logic          jmp,
    input  logic [W-1:0]  jmp_st,
    input  logic [DW-1:0] tmo_lim,
    output logic [W-1:0]  st,
    output logic [NS-1:0] st_oh,
    output logic          entry,
    output logic [DW-1:0] dwell,
    output logic          tmo,
    output logic          jerr,
    output logic          last
);

    typedef enum logic [2:0] {K_HOLD, K_RESYNC, K_LOAD, K_FWD, K_BACK} step_e;

    localparam logic [W:0]   NS_V  = (W+1)'(NS);
    localparam logic [W-1:0] LST_V = W'(NS - 1);

    step_e         kind;
    logic [W-1:0]  st_nxt;
    logic          trans;
    logic          st_bad;
    logic          jok;
    logic          fired;

    assign st_bad = {1'b0, st} >= NS_V;
    assign jok    = {1'b0, jmp_st} < NS_V;
    assign last   = (st == LST_V);

    for (genvar i = 0; i < NS; i++) begin : g_oh
        assign st_oh[i] = (st == W'(i));
    end

    // End-of-range holds under WRAP=0 stay K_HOLD so they never count as a transition.
    always_comb begin
        kind   = K_HOLD;
        st_nxt = st;
        trans  = 1'b0;
        if (st_bad)
            kind = K_RESYNC;
        else if (jmp && jok)
            kind = K_LOAD;
        else if (adv[st]) begin
            if (!last || WRAP) kind = K_FWD;
        end else if (bck) begin
            if (st != '0 || WRAP) kind = K_BACK;
        end

        case (kind)
            K_RESYNC: begin st_nxt = '0;                             trans = 1'b1; end
            K_LOAD:   begin st_nxt = jmp_st;                         trans = 1'b1; end
            K_FWD:    begin st_nxt = last ? '0 : st + W'(1);         trans = 1'b1; end
            K_BACK:   begin st_nxt = (st == '0) ? LST_V : st - W'(1); trans = 1'b1; end
            default:  begin st_nxt = st;                             trans = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= '0;
            entry <= 1'b0;
            dwell <= '0;
            tmo   <= 1'b0;
            jerr  <= 1'b0;
            fired <= 1'b0;
        end else begin
            st    <= st_nxt;
            entry <= trans;
            jerr  <= jmp && !jok;
            if (trans) begin
                dwell <= '0;
                tmo   <= 1'b0;
                fired <= 1'b0;
            end else begin
                if (dwell != '1) dwell <= dwell + DW'(1);
                // fired keeps a lowered tmo_lim from re-triggering within the same visit
                if (tmo_lim != '0 && !fired && dwell == tmo_lim - DW'(1)) begin
                    tmo   <= 1'b1;
                    fired <= 1'b1;
                end else begin
                    tmo   <= 1'b0;
                end
            end
        end
    end

endmodule
